// File: rtl/vend_if.sv
// Coin-acceptor / hopper signal bundle for vend_sequencer.
// master = sequencer side, slave = coin acceptor and hopper side.
interface vend_if;
  // Handshake: each *_req is raised by the sequencer and held until the
  // matching *_ack is sampled high on a clock edge. One sampled ack
  // releases exactly one item or coin. The mechanism drops ack the cycle
  // after it is sampled. An ack is ignored while its req is low.
  // At most one req is high at a time.
  logic       coin_f;
  logic       coin_h;
  logic       coin_p;
  logic       refund;
  logic       item_req;
  logic       item_ack;
  logic       half_req;
  logic       half_ack;
  logic       qtr_req;
  logic       qtr_ack;
  logic [3:0] credit;
  logic       busy;
  logic       coin_reject;
  logic [1:0] dbg_state;

  modport master (
    input  coin_f, coin_h, coin_p, refund,
    input  item_ack, half_ack, qtr_ack,
    output item_req, half_req, qtr_req,
    output credit, busy, coin_reject, dbg_state
  );

  modport slave (
    output coin_f, coin_h, coin_p, refund,
    output item_ack, half_ack, qtr_ack,
    input  item_req, half_req, qtr_req,
    input  credit, busy, coin_reject, dbg_state
  );
endinterface

// File: rtl/vend_sequencer.sv
// Tomato-machine vend sequencer: farthing credit, item vend, greedy change payout.
// Optional feature macro: VEND_REFUND_EN (refund pulse pays credit back as change).
module vend_sequencer #(
  parameter int PRICE = 4
) (
  input  logic   clk,
  input  logic   reset,
  vend_if.master bus
);

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    VEND   = 2'd1,
    PAY_H  = 2'd2,
    PAY_Q  = 2'd3
  } state_t;

  state_t     state;
  logic [3:0] credit_q;
  logic       item_req_q;
  logic       half_req_q;
  logic       qtr_req_q;
  logic       busy_q;
  logic       coin_reject_q;

  logic [1:0] n_coins;
  logic       any_coin;
  logic [3:0] coin_val;
  logic [3:0] sum;
  logic [3:0] after_vend;
  logic [3:0] after_half;
  logic       refund_go;

  // Greedy change routing: halves while at least 2 remain, then one farthing.
  function automatic state_t route(input logic [3:0] c);
    if (c >= 4'd2) return PAY_H;
    if (c == 4'd1) return PAY_Q;
    return ACCEPT;
  endfunction

  always_comb begin
    n_coins    = 2'(bus.coin_f) + 2'(bus.coin_h) + 2'(bus.coin_p);
    any_coin   = bus.coin_f | bus.coin_h | bus.coin_p;
    coin_val   = bus.coin_f ? 4'd1 : (bus.coin_h ? 4'd2 : 4'd4);
    sum        = credit_q + coin_val;
    after_vend = credit_q - 4'(PRICE);
    after_half = credit_q - 4'd2;
  end

`ifdef VEND_REFUND_EN
  assign refund_go = bus.refund && (credit_q != 4'd0);
`else
  logic unused_refund;
  assign unused_refund = bus.refund;
  assign refund_go     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ACCEPT;
      credit_q      <= 4'd0;
      item_req_q    <= 1'b0;
      half_req_q    <= 1'b0;
      qtr_req_q     <= 1'b0;
      busy_q        <= 1'b0;
      coin_reject_q <= 1'b0;
    end else begin
      coin_reject_q <= 1'b0;
      case (state)
        ACCEPT: begin
          if (refund_go) begin
            // Refund wins over any coin presented in the same cycle.
            coin_reject_q <= any_coin;
            state         <= route(credit_q);
            half_req_q    <= (route(credit_q) == PAY_H);
            qtr_req_q     <= (route(credit_q) == PAY_Q);
            busy_q        <= 1'b1;
          end else if (n_coins == 2'd1) begin
            credit_q <= sum;
            if (sum >= 4'(PRICE)) begin
              state      <= VEND;
              item_req_q <= 1'b1;
              busy_q     <= 1'b1;
            end
          end else if (n_coins >= 2'd2) begin
            coin_reject_q <= 1'b1;
          end
        end
        VEND: begin
          coin_reject_q <= any_coin;
          if (bus.item_ack) begin
            credit_q   <= after_vend;
            item_req_q <= 1'b0;
            state      <= route(after_vend);
            half_req_q <= (route(after_vend) == PAY_H);
            qtr_req_q  <= (route(after_vend) == PAY_Q);
            busy_q     <= (route(after_vend) != ACCEPT);
          end
        end
        PAY_H: begin
          coin_reject_q <= any_coin;
          if (bus.half_ack) begin
            credit_q   <= after_half;
            state      <= route(after_half);
            half_req_q <= (route(after_half) == PAY_H);
            qtr_req_q  <= (route(after_half) == PAY_Q);
            busy_q     <= (route(after_half) != ACCEPT);
          end
        end
        PAY_Q: begin
          coin_reject_q <= any_coin;
          if (bus.qtr_ack) begin
            credit_q  <= credit_q - 4'd1;
            qtr_req_q <= 1'b0;
            busy_q    <= 1'b0;
            state     <= ACCEPT;
          end
        end
        default: state <= ACCEPT;
      endcase
    end
  end

  assign bus.item_req    = item_req_q;
  assign bus.half_req    = half_req_q;
  assign bus.qtr_req     = qtr_req_q;
  assign bus.credit      = credit_q;
  assign bus.busy        = busy_q;
  assign bus.coin_reject = coin_reject_q;
  assign bus.dbg_state   = state;

endmodule
